// File: rtl/hazard_fwd_scoreboard_if.sv
// Decode-side bundle between the RISC-8 ID stage and the hazard/forwarding scoreboard.
// The scoreboard takes the slave modport; the pipeline (or a bench) takes master.
interface hazard_fwd_scoreboard_if #(
  parameter int REG_AW     = 3,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int CNT_W      = 16
);
  localparam int SELW = $clog2(FWD_STAGES + 1);

  logic                        i_dec_valid;
  logic [NUM_SRC*REG_AW-1:0]   i_dec_rs;
  logic [NUM_SRC-1:0]          i_dec_uses;
  logic [REG_AW-1:0]           i_dec_rd;
  logic                        i_dec_regwrite;
  logic                        i_dec_is_load;
  logic                        i_flush;
  logic [NUM_SRC*SELW-1:0]     o_fwd_sel;
  logic                        o_stall;
  logic                        o_bubble;
  logic [CNT_W-1:0]            o_stall_count;

  modport slave (
    input  i_dec_valid, i_dec_rs, i_dec_uses, i_dec_rd, i_dec_regwrite, i_dec_is_load, i_flush,
    output o_fwd_sel, o_stall, o_bubble, o_stall_count
  );

  modport master (
    output i_dec_valid, i_dec_rs, i_dec_uses, i_dec_rd, i_dec_regwrite, i_dec_is_load, i_flush,
    input  o_fwd_sel, o_stall, o_bubble, o_stall_count
  );
endinterface

// File: rtl/hazard_fwd_scoreboard.sv
// Forwarding-select and load-use stall controller for the RISC-8 pipeline.
// Tracks the EX instruction plus FWD_STAGES older producers; position 0 is EX, k is Pk.
module hazard_fwd_scoreboard #(
  parameter int REG_AW     = 3,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  hazard_fwd_scoreboard_if.slave  bus
);
  localparam int SELW = $clog2(FWD_STAGES + 1);

  logic                        r_ex_valid;
  logic [NUM_SRC*REG_AW-1:0]   r_ex_rs;
  logic [NUM_SRC-1:0]          r_ex_uses;
  logic [REG_AW-1:0]           r_ex_rd;
  logic                        r_ex_rw;
  logic                        r_ex_ld;

  logic [FWD_STAGES:1]         r_p_valid;
  logic [FWD_STAGES:1]         r_p_rw;
  logic [FWD_STAGES:1]         r_p_ld;
  logic [REG_AW-1:0]           r_p_rd [1:FWD_STAGES];

  logic [CNT_W-1:0]            r_stall_count;

  logic [FWD_STAGES:0]         w_pv;
  logic [FWD_STAGES:0]         w_prw;
  logic [FWD_STAGES:0]         w_pld;
  logic [REG_AW-1:0]           w_prd [0:FWD_STAGES];
  logic [NUM_SRC*SELW-1:0]     w_fwd_sel;
  logic [NUM_SRC-1:0]          w_stall_src;
  logic                        w_yld;
  logic                        w_ynear;
  logic                        w_stall;
  logic                        w_issue;

  assign w_pv  = {r_p_valid, r_ex_valid};
  assign w_prw = {r_p_rw, r_ex_rw};
  assign w_pld = {r_p_ld, r_ex_ld};

  always_comb begin
    w_prd[0] = r_ex_rd;
    for (int k = 1; k <= FWD_STAGES; k++) begin
      w_prd[k] = r_p_rd[k];
    end
  end

  // Walking oldest-to-youngest lets the youngest producer overwrite older ones.
  always_comb begin
    w_fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = FWD_STAGES; k >= 1; k--) begin
        if (r_ex_valid && r_ex_uses[i] && r_p_valid[k] && r_p_rw[k] &&
            (r_p_rd[k] != '0) && (r_p_rd[k] == r_ex_rs[i*REG_AW +: REG_AW])) begin
          w_fwd_sel[i*SELW +: SELW] = SELW'(k);
        end
      end
    end
  end

  always_comb begin
    w_stall_src = '0;
    w_yld       = 1'b0;
    w_ynear     = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_yld   = 1'b0;
      w_ynear = 1'b0;
      for (int j = FWD_STAGES; j >= 0; j--) begin
        if (w_pv[j] && w_prw[j] && (w_prd[j] != '0) &&
            (w_prd[j] == bus.i_dec_rs[i*REG_AW +: REG_AW])) begin
          w_yld   = w_pld[j];
          w_ynear = (j < LOAD_LAT);
        end
      end
      w_stall_src[i] = bus.i_dec_uses[i] & w_yld & w_ynear;
    end
  end

  assign w_stall = bus.i_dec_valid & ~bus.i_flush & (|w_stall_src);
  assign w_issue = bus.i_dec_valid & ~w_stall & ~bus.i_flush;

  // Producer history shifts every edge, even while ID is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid    <= 1'b0;
      r_ex_uses     <= '0;
      r_p_valid     <= '0;
      r_stall_count <= '0;
    end else begin
      r_p_valid[1] <= r_ex_valid;
      r_p_rw[1]    <= r_ex_rw;
      r_p_ld[1]    <= r_ex_ld;
      r_p_rd[1]    <= r_ex_rd;
      for (int k = 2; k <= FWD_STAGES; k++) begin
        r_p_valid[k] <= r_p_valid[k-1];
        r_p_rw[k]    <= r_p_rw[k-1];
        r_p_ld[k]    <= r_p_ld[k-1];
        r_p_rd[k]    <= r_p_rd[k-1];
      end
      if (w_issue) begin
        r_ex_valid <= 1'b1;
        r_ex_rs    <= bus.i_dec_rs;
        r_ex_uses  <= bus.i_dec_uses;
        r_ex_rd    <= bus.i_dec_rd;
        r_ex_rw    <= bus.i_dec_regwrite;
        r_ex_ld    <= bus.i_dec_is_load;
      end else begin
        r_ex_valid <= 1'b0;
        r_ex_uses  <= '0;
      end
      if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  assign bus.o_fwd_sel     = w_fwd_sel;
  assign bus.o_stall       = w_stall;
  assign bus.o_bubble      = w_stall | bus.i_flush;
  assign bus.o_stall_count = r_stall_count;
endmodule
